// File: rtl/ceespu_fetch.sv
// ceespu_fetch: instruction-fetch stage, PC owner with one-entry skid register feeding decode.
// Define CEESPU_FETCH_INT_EN to enable interrupt-entry injection.
module ceespu_fetch #(
   parameter logic [13:0] RESET_PC   = 14'h0000,
   parameter logic [13:0] INT_VECTOR = 14'h0004,
   parameter logic [31:0] NOP_INSTR  = 32'h00000000,
   parameter logic [31:0] INT_INSTR  = 32'h00000000
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_stall,
   input  logic        I_branch,
   input  logic [13:0] I_branchTarget,
   input  logic        I_interrupt,
   input  logic        I_interrupts_enabled,
   input  logic [31:0] I_imem_data,
   output logic [13:0] O_imem_addr,
   output logic [31:0] O_instruction,
   output logic [13:0] O_PC,
   output logic        O_valid,
   output logic        O_did_interrupt
);
   typedef enum logic {S_BUBBLE, S_RUN} state_t;
   state_t      state, state_n;
   logic [13:0] pc_q, issued_pc;
   logic        issued_v, skid_v, take;
   logic [31:0] skid;
`ifdef CEESPU_FETCH_INT_EN
   assign take = I_interrupt & I_interrupts_enabled & !I_stall & !I_branch & (state == S_RUN);
`else
   logic unused_int;
   assign unused_int = I_interrupt ^ I_interrupts_enabled;
   assign take = 1'b0;
`endif
   assign O_imem_addr = pc_q;
   always_comb begin
      state_n         = (I_branch || take) ? S_BUBBLE : S_RUN;
      O_PC            = issued_pc;
      O_did_interrupt = take;
      O_valid         = take || (state == S_RUN && issued_v);
      O_instruction   = take ? INT_INSTR : (state == S_BUBBLE) ? NOP_INSTR : skid_v ? skid : I_imem_data;
   end
   // A bubble ignores stall: nothing valid is presented, so it can safely issue the next fetch.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state     <= S_BUBBLE;
         pc_q      <= RESET_PC;
         issued_pc <= 14'd0;
         issued_v  <= 1'b0;
         skid_v    <= 1'b0;
         skid      <= 32'd0;
      end else begin
         state <= state_n;
         if (I_branch) begin
            pc_q     <= I_branchTarget;
            issued_v <= 1'b0;
            skid_v   <= 1'b0;
         end else if (take) begin
            pc_q     <= INT_VECTOR;
            issued_v <= 1'b0;
            skid_v   <= 1'b0;
         end else if (state == S_BUBBLE || !I_stall) begin
            pc_q      <= pc_q + 14'd1;
            issued_pc <= pc_q;
            issued_v  <= 1'b1;
            skid_v    <= 1'b0;
         end else if (!skid_v) begin
            skid   <= I_imem_data;
            skid_v <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_ceespu_fetch.sv
// tb_ceespu_fetch: directed self-checking bench for ceespu_fetch with a synchronous RAM model.
module tb_ceespu_fetch;
   localparam logic [31:0] INT_I = 32'hE800_0011;
   logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, branch = 1'b0, intr = 1'b0, int_en = 1'b0;
   logic [13:0] target = 14'd0;
   logic [31:0] imem_data = 32'd0;
   logic [13:0] imem_addr, pc;
   logic [31:0] instr;
   logic        valid, did_int;
   logic [61:0] obs, exp;
   logic [47:0] bobs, bexp;
   int          checks = 0, errors = 0;

   ceespu_fetch #(.INT_INSTR(INT_I)) dut (
      .I_clk(clk), .I_rst(rst), .I_stall(stall), .I_branch(branch), .I_branchTarget(target),
      .I_interrupt(intr), .I_interrupts_enabled(int_en), .I_imem_data(imem_data),
      .O_imem_addr(imem_addr), .O_instruction(instr), .O_PC(pc), .O_valid(valid),
      .O_did_interrupt(did_int)
   );

   always #5 clk = ~clk;
   always @(posedge clk) imem_data <= 32'h1000_0000 + {18'd0, imem_addr};

   assign obs  = {valid, did_int, pc, imem_addr, instr};
   assign bobs = {valid, did_int, imem_addr, instr};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      #1 exp = {1'b0, 1'b0, 14'h0000, 14'h0000, 32'h0};
      checks++; if (obs !== exp) begin errors++; $display("FAIL reset_held: got %h want %h", obs, exp); end
      step();
      rst = 1'b0;
      #1 exp = {1'b0, 1'b0, 14'h0000, 14'h0000, 32'h0};
      checks++; if (obs !== exp) begin errors++; $display("FAIL reset_bubble: got %h want %h", obs, exp); end
   endtask

   task automatic test_run();
      for (int i = 0; i < 3; i++) begin
         step();
         #1 exp = {1'b1, 1'b0, 14'(i), 14'(i + 1), 32'h1000_0000 + 32'(i)};
         checks++; if (obs !== exp) begin errors++; $display("FAIL run_%0d: got %h want %h", i, obs, exp); end
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 exp = {1'b1, 1'b0, 14'h0002, 14'h0003, 32'h1000_0002};
         checks++; if (obs !== exp) begin errors++; $display("FAIL stall_%0d: got %h want %h", i, obs, exp); end
         step();
      end
      stall = 1'b0;
      #1 exp = {1'b1, 1'b0, 14'h0002, 14'h0003, 32'h1000_0002};
      checks++; if (obs !== exp) begin errors++; $display("FAIL stall_release: got %h want %h", obs, exp); end
      for (int i = 3; i < 6; i++) begin
         step();
         #1 exp = {1'b1, 1'b0, 14'(i), 14'(i + 1), 32'h1000_0000 + 32'(i)};
         checks++; if (obs !== exp) begin errors++; $display("FAIL after_stall_%0d: got %h want %h", i, obs, exp); end
      end
   endtask

   task automatic test_branch();
      branch = 1'b1;
      target = 14'h0100;
      #1 exp = {1'b1, 1'b0, 14'h0005, 14'h0006, 32'h1000_0005};
      checks++; if (obs !== exp) begin errors++; $display("FAIL branch_cycle: got %h want %h", obs, exp); end
      step();
      branch = 1'b0;
      #1 bexp = {1'b0, 1'b0, 14'h0100, 32'h0};
      checks++; if (bobs !== bexp) begin errors++; $display("FAIL branch_bubble: got %h want %h", bobs, bexp); end
      step();
      #1 exp = {1'b1, 1'b0, 14'h0100, 14'h0101, 32'h1000_0100};
      checks++; if (obs !== exp) begin errors++; $display("FAIL branch_target: got %h want %h", obs, exp); end
      step();
      #1 exp = {1'b1, 1'b0, 14'h0101, 14'h0102, 32'h1000_0101};
      checks++; if (obs !== exp) begin errors++; $display("FAIL branch_next: got %h want %h", obs, exp); end
   endtask

   task automatic test_branch_stall();
      branch = 1'b1;
      stall  = 1'b1;
      target = 14'h0100;
      step();
      branch = 1'b0;
      stall  = 1'b0;
      #1 bexp = {1'b0, 1'b0, 14'h0100, 32'h0};
      checks++; if (bobs !== bexp) begin errors++; $display("FAIL bstall_bubble: got %h want %h", bobs, bexp); end
      step();
      #1 exp = {1'b1, 1'b0, 14'h0100, 14'h0101, 32'h1000_0100};
      checks++; if (obs !== exp) begin errors++; $display("FAIL bstall_target: got %h want %h", obs, exp); end
   endtask

   task automatic test_interrupt();
      branch = 1'b1;
      target = 14'h0007;
      step();
      branch = 1'b0;
      step();
      intr   = 1'b1;
      int_en = 1'b1;
`ifdef CEESPU_FETCH_INT_EN
      #1 exp = {1'b1, 1'b1, 14'h0007, 14'h0008, INT_I};
      checks++; if (obs !== exp) begin errors++; $display("FAIL int_take: got %h want %h", obs, exp); end
      step();
      intr = 1'b0;
      #1 bexp = {1'b0, 1'b0, 14'h0004, 32'h0};
      checks++; if (bobs !== bexp) begin errors++; $display("FAIL int_bubble: got %h want %h", bobs, bexp); end
      step();
      #1 exp = {1'b1, 1'b0, 14'h0004, 14'h0005, 32'h1000_0004};
      checks++; if (obs !== exp) begin errors++; $display("FAIL int_vector: got %h want %h", obs, exp); end
      stall = 1'b1;
      intr  = 1'b1;
      step();
      #1 exp = {1'b1, 1'b0, 14'h0004, 14'h0005, 32'h1000_0004};
      checks++; if (obs !== exp) begin errors++; $display("FAIL int_stalled: got %h want %h", obs, exp); end
      stall = 1'b0;
      intr  = 1'b0;
      step();
      #1 exp = {1'b1, 1'b0, 14'h0005, 14'h0006, 32'h1000_0005};
      checks++; if (obs !== exp) begin errors++; $display("FAIL int_resume: got %h want %h", obs, exp); end
`else
      #1 exp = {1'b1, 1'b0, 14'h0007, 14'h0008, 32'h1000_0007};
      checks++; if (obs !== exp) begin errors++; $display("FAIL int_ignored: got %h want %h", obs, exp); end
      step();
      intr = 1'b0;
      #1 exp = {1'b1, 1'b0, 14'h0008, 14'h0009, 32'h1000_0008};
      checks++; if (obs !== exp) begin errors++; $display("FAIL int_ignored_next: got %h want %h", obs, exp); end
`endif
      int_en = 1'b0;
   endtask

   task automatic test_int_disabled();
      branch = 1'b1;
      target = 14'h0020;
      step();
      branch = 1'b0;
      step();
      intr   = 1'b1;
      int_en = 1'b0;
      #1 exp = {1'b1, 1'b0, 14'h0020, 14'h0021, 32'h1000_0020};
      checks++; if (obs !== exp) begin errors++; $display("FAIL intdis_cycle: got %h want %h", obs, exp); end
      step();
      #1 exp = {1'b1, 1'b0, 14'h0021, 14'h0022, 32'h1000_0021};
      checks++; if (obs !== exp) begin errors++; $display("FAIL intdis_next: got %h want %h", obs, exp); end
      intr = 1'b0;
   endtask

   task automatic test_wrap();
      branch = 1'b1;
      target = 14'h3FFE;
      step();
      branch = 1'b0;
      step();
      #1 exp = {1'b1, 1'b0, 14'h3FFE, 14'h3FFF, 32'h1000_3FFE};
      checks++; if (obs !== exp) begin errors++; $display("FAIL wrap_3ffe: got %h want %h", obs, exp); end
      step();
      #1 exp = {1'b1, 1'b0, 14'h3FFF, 14'h0000, 32'h1000_3FFF};
      checks++; if (obs !== exp) begin errors++; $display("FAIL wrap_3fff: got %h want %h", obs, exp); end
      step();
      #1 exp = {1'b1, 1'b0, 14'h0000, 14'h0001, 32'h1000_0000};
      checks++; if (obs !== exp) begin errors++; $display("FAIL wrap_0000: got %h want %h", obs, exp); end
   endtask

   task automatic test_midreset();
      rst = 1'b1;
      step();
      #1 exp = {1'b0, 1'b0, 14'h0000, 14'h0000, 32'h0};
      checks++; if (obs !== exp) begin errors++; $display("FAIL midreset: got %h want %h", obs, exp); end
      rst = 1'b0;
      step();
      #1 exp = {1'b1, 1'b0, 14'h0000, 14'h0001, 32'h1000_0000};
      checks++; if (obs !== exp) begin errors++; $display("FAIL midreset_run: got %h want %h", obs, exp); end
   endtask

   initial begin
      test_reset();
      test_run();
      test_stall();
      test_branch();
      test_branch_stall();
      test_interrupt();
      test_int_disabled();
      test_wrap();
      test_midreset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
